pipe_stall_ctrl: RTL and testbench

- Central pipeline stall/flush controller for the 5-stage MIPS core (pc, if, id, ex, mem, wb).
- Merges the ID-stage stall request (load-use), the EX-stage stall request, and multi-cycle EX operations (div/madd) into one per-stage stall vector.
- Sequences multi-cycle ops with an internal cycle counter, and sequences an exception/branch flush window.
- Sits beside the pipeline registers; every pipeline register consumes stall/flush.

---
 rtl/pipe_stall_ctrl_pkg.sv | 25 ++
 rtl/pipe_stall_ctrl_mc_cycle_counter.sv | 40 ++++
 rtl/pipe_stall_ctrl.sv | 162 ++++++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller:
// stage bit positions, stall-vector constants and FSM state encoding.
package pipe_ctrl_pkg;

  localparam int unsigned STG_PC     = 0;
  localparam int unsigned STG_IF     = 1;
  localparam int unsigned STG_ID     = 2;
  localparam int unsigned STG_EX     = 3;
  localparam int unsigned STG_MEM    = 4;
  localparam int unsigned STG_WB     = 5;
  localparam int unsigned NUM_STAGES = 6;

  // MEM and WB are never stalled so in-flight results keep draining.
  localparam logic [NUM_STAGES-1:0] STALL_NONE = 6'b000000;
  localparam logic [NUM_STAGES-1:0] STALL_ID   = 6'b000111;
  localparam logic [NUM_STAGES-1:0] STALL_EX   = 6'b001111;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MC_RUN  = 2'd1,
    ST_MC_DONE = 2'd2,
    ST_FLUSH   = 2'd3
  } ctrl_state_e;

endpackage

// File: rtl/pipe_stall_ctrl_mc_cycle_counter.sv
// Loadable down-counter with terminal-count flag (count <= 1).
// Used for both the multi-cycle op length and the flush window length.
module mc_cycle_counter
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             tc_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: load wins over decrement; decrement saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Count register, synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q <= CNT_W'(1));

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline.
// Merges ID/EX stall requests and multi-cycle EX ops into one per-stage
// stall vector and sequences the exception/redirect flush window.
// Optional stalled-cycle counter enabled by macro PIPE_STALL_PERF_EN.
module pipe_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W     = 6,
  parameter int unsigned FLUSH_LEN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_id,
  input  logic             stallreq_ex,
  input  logic             mc_start,
  input  logic [CNT_W-1:0] mc_cycles,
  input  logic             flush_req,
  output logic [5:0]       stall,
  output logic             flush,
  output logic             mc_busy,
  output logic             mc_done,
  output logic [31:0]      stall_cycles
);

  localparam logic [CNT_W-1:0] FLUSH_RELOAD = CNT_W'(FLUSH_LEN - 1);

  ctrl_state_e      state_q;
  ctrl_state_e      state_d;

  logic             mc_load;
  logic [CNT_W-1:0] mc_load_val;
  logic             mc_dec;
  logic             mc_tc;
  logic             fl_load;
  logic             fl_dec;
  logic             fl_tc;

  mc_cycle_counter #(.CNT_W(CNT_W)) u_mc_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (mc_load),
    .load_val_i (mc_load_val),
    .dec_i      (mc_dec),
    .tc_o       (mc_tc)
  );

  mc_cycle_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (fl_load),
    .load_val_i (FLUSH_RELOAD),
    .dec_i      (fl_dec),
    .tc_o       (fl_tc)
  );

  // State register, synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, counter control and combinational stall/flush outputs.
  // The start cycle itself counts as the first stalled cycle, so MC_RUN
  // lasts N-1 cycles (counter loaded with N-1) and N<=1 skips straight to
  // MC_DONE. The flush window likewise leaves FLUSH when the counter is at
  // its terminal count, giving FLUSH_LEN asserted cycles in total.
  always_comb begin
    state_d     = state_q;
    stall       = STALL_NONE;
    flush       = 1'b0;
    mc_load     = 1'b0;
    mc_load_val = mc_cycles - CNT_W'(1);
    mc_dec      = 1'b0;
    fl_load     = 1'b0;
    fl_dec      = 1'b0;

    if (flush_req) begin
      flush   = 1'b1;
      fl_load = 1'b1;
      state_d = (FLUSH_LEN > 1) ? ST_FLUSH : ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (mc_start) begin
            stall   = STALL_EX;
            mc_load = 1'b1;
            state_d = (mc_cycles <= CNT_W'(1)) ? ST_MC_DONE : ST_MC_RUN;
          end else if (stallreq_ex) begin
            stall = STALL_EX;
          end else if (stallreq_id) begin
            stall = STALL_ID;
          end
        end
        ST_MC_RUN: begin
          stall = STALL_EX;
          if (mc_tc) begin
            state_d = ST_MC_DONE;
          end else begin
            mc_dec = 1'b1;
          end
        end
        ST_MC_DONE: begin
          state_d = ST_IDLE;
          if (stallreq_ex) begin
            stall = STALL_EX;
          end else if (stallreq_id) begin
            stall = STALL_ID;
          end
        end
        ST_FLUSH: begin
          flush = 1'b1;
          if (fl_tc) begin
            state_d = ST_IDLE;
          end else begin
            fl_dec = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    if (rst) begin
      stall = STALL_NONE;
      flush = 1'b0;
    end
  end

  assign mc_busy = ~rst & (state_q == ST_MC_RUN);
  assign mc_done = ~rst & (state_q == ST_MC_DONE);

`ifdef PIPE_STALL_PERF_EN
  logic [31:0] stall_cycles_q;
  logic [31:0] stall_cycles_d;

  // Next stalled-cycle count; wraps naturally at 2^32.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall[STG_PC]) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
  end

  // Stalled-cycle counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed self-checking bench for pipe_stall_ctrl (FLUSH_LEN=3).
// Inputs change 1 time unit after the rising edge; outputs are sampled
// on the falling edge.
module tb_pipe_stall_ctrl;

  localparam int unsigned CNT_W = 6;

  logic             clk = 1'b0;
  logic             rst;
  logic             stallreq_id;
  logic             stallreq_ex;
  logic             mc_start;
  logic [CNT_W-1:0] mc_cycles;
  logic             flush_req;
  logic [5:0]       stall;
  logic             flush;
  logic             mc_busy;
  logic             mc_done;
  logic [31:0]      stall_cycles;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned done_pulses = 0;

  always #5 clk = ~clk;

  pipe_stall_ctrl #(.CNT_W(CNT_W), .FLUSH_LEN(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .stallreq_id  (stallreq_id),
    .stallreq_ex  (stallreq_ex),
    .mc_start     (mc_start),
    .mc_cycles    (mc_cycles),
    .flush_req    (flush_req),
    .stall        (stall),
    .flush        (flush),
    .mc_busy      (mc_busy),
    .mc_done      (mc_done),
    .stall_cycles (stall_cycles)
  );

  // Count every mc_done pulse seen over the whole run.
  always @(negedge clk) begin
    if (mc_done) done_pulses++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic check_out(input string tag, input logic [5:0] e_stall, input logic e_flush,
                           input logic e_busy, input logic e_done);
    check_eq({tag, ".stall"}, 32'(stall), 32'(e_stall));
    check_eq({tag, ".flush"}, 32'(flush), 32'(e_flush));
    check_eq({tag, ".busy"},  32'(mc_busy), 32'(e_busy));
    check_eq({tag, ".done"},  32'(mc_done), 32'(e_done));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; stallreq_id = 1'b0; stallreq_ex = 1'b0;
    mc_start = 1'b0; mc_cycles = '0; flush_req = 1'b0;

    // Reset state
    next_cycle(); next_cycle();
    sample();
    check_out("reset", 6'b000000, 1'b0, 1'b0, 1'b0);
    check_eq("reset.perf", stall_cycles, 32'h0);

    // Reset in the middle of an N=5 op
    next_cycle(); rst = 1'b0; mc_start = 1'b1; mc_cycles = 6'd5;
    sample(); check_out("rstmc.T", 6'b001111, 1'b0, 1'b0, 1'b0);
    next_cycle(); mc_start = 1'b0;
    sample(); check_out("rstmc.T1", 6'b001111, 1'b0, 1'b1, 1'b0);
    next_cycle(); rst = 1'b1;
    sample(); check_out("rstmc.rst", 6'b000000, 1'b0, 1'b0, 1'b0);
    next_cycle(); rst = 1'b0;
    sample(); check_out("rstmc.after", 6'b000000, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) next_cycle();
    sample(); check_eq("rstmc.nodone", done_pulses, 32'd0);

    // ID-only stall for two cycles
    next_cycle(); stallreq_id = 1'b1;
    sample(); check_out("id.c0", 6'b000111, 1'b0, 1'b0, 1'b0);
    next_cycle();
    sample(); check_out("id.c1", 6'b000111, 1'b0, 1'b0, 1'b0);
    next_cycle(); stallreq_id = 1'b0;
    sample(); check_out("id.c2", 6'b000000, 1'b0, 1'b0, 1'b0);

    // ID and EX together
    next_cycle(); stallreq_id = 1'b1; stallreq_ex = 1'b1;
    sample(); check_out("idex", 6'b001111, 1'b0, 1'b0, 1'b0);
    next_cycle(); stallreq_id = 1'b0; stallreq_ex = 1'b0;

    // N=4 op, second mc_start at T+2 ignored
    next_cycle(); mc_start = 1'b1; mc_cycles = 6'd4;
    sample(); check_out("mc4.T", 6'b001111, 1'b0, 1'b0, 1'b0);
    next_cycle(); mc_start = 1'b0;
    sample(); check_out("mc4.T1", 6'b001111, 1'b0, 1'b1, 1'b0);
    next_cycle(); mc_start = 1'b1; mc_cycles = 6'd2;
    sample(); check_out("mc4.T2", 6'b001111, 1'b0, 1'b1, 1'b0);
    next_cycle(); mc_start = 1'b0;
    sample(); check_out("mc4.T3", 6'b001111, 1'b0, 1'b1, 1'b0);
    next_cycle();
    sample(); check_out("mc4.T4", 6'b000000, 1'b0, 1'b0, 1'b1);
    next_cycle();
    sample(); check_out("mc4.T5", 6'b000000, 1'b0, 1'b0, 1'b0);

    // N=0 behaves as N=1
    next_cycle(); mc_start = 1'b1; mc_cycles = 6'd0;
    sample(); check_out("mc0.T", 6'b001111, 1'b0, 1'b0, 1'b0);
    next_cycle(); mc_start = 1'b0;
    sample(); check_out("mc0.T1", 6'b000000, 1'b0, 1'b0, 1'b1);
    next_cycle();
    sample(); check_out("mc0.T2", 6'b000000, 1'b0, 1'b0, 1'b0);

    // N=2 op with stallreq_ex arriving during MC_DONE
    next_cycle(); mc_start = 1'b1; mc_cycles = 6'd2;
    sample(); check_out("mc2.T", 6'b001111, 1'b0, 1'b0, 1'b0);
    next_cycle(); mc_start = 1'b0;
    sample(); check_out("mc2.T1", 6'b001111, 1'b0, 1'b1, 1'b0);
    next_cycle(); stallreq_ex = 1'b1;
    sample(); check_out("mc2.T2", 6'b001111, 1'b0, 1'b0, 1'b1);
    next_cycle(); stallreq_ex = 1'b0;
    sample(); check_out("mc2.T3", 6'b000000, 1'b0, 1'b0, 1'b0);

    // Flush at T+2 of an N=5 op, FLUSH_LEN=3
    next_cycle(); mc_start = 1'b1; mc_cycles = 6'd5;
    sample(); check_out("fl.T", 6'b001111, 1'b0, 1'b0, 1'b0);
    next_cycle(); mc_start = 1'b0;
    sample(); check_out("fl.T1", 6'b001111, 1'b0, 1'b1, 1'b0);
    next_cycle(); flush_req = 1'b1;
    sample(); check_out("fl.T2", 6'b000000, 1'b1, 1'b1, 1'b0);
    next_cycle(); flush_req = 1'b0; stallreq_ex = 1'b1;
    sample(); check_out("fl.T3", 6'b000000, 1'b1, 1'b0, 1'b0);
    next_cycle(); stallreq_ex = 1'b0; mc_start = 1'b1; mc_cycles = 6'd3;
    sample(); check_out("fl.T4", 6'b000000, 1'b1, 1'b0, 1'b0);
    next_cycle(); mc_start = 1'b0;
    sample(); check_out("fl.T5", 6'b000000, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) next_cycle();

    // flush_req inside FLUSH extends the window
    next_cycle(); flush_req = 1'b1;
    sample(); check_eq("flx.X.flush", 32'(flush), 32'd1);
    next_cycle();
    sample(); check_eq("flx.X1.flush", 32'(flush), 32'd1);
    next_cycle(); flush_req = 1'b0;
    sample(); check_eq("flx.X2.flush", 32'(flush), 32'd1);
    next_cycle();
    sample(); check_eq("flx.X3.flush", 32'(flush), 32'd1);
    next_cycle();
    sample(); check_out("flx.X4", 6'b000000, 1'b0, 1'b0, 1'b0);

    // Total mc_done pulses: N=4, N=0, N=2 ops only
    check_eq("done.total", done_pulses, 32'd3);

    // Stalled-cycle counter
    next_cycle(); rst = 1'b1;
    next_cycle(); rst = 1'b0; stallreq_id = 1'b1;
    for (int i = 0; i < 9; i++) next_cycle();
    next_cycle(); stallreq_id = 1'b0;
    sample();
`ifdef PIPE_STALL_PERF_EN
    check_eq("perf.ten", stall_cycles, 32'd10);
    next_cycle(); stallreq_id = 1'b1;
    dut.stall_cycles_q = 32'hFFFF_FFFF;
    next_cycle(); stallreq_id = 1'b0;
    sample();
    check_eq("perf.wrap", stall_cycles, 32'h0);
`else
    check_eq("perf.off", stall_cycles, 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
